junction_cycle_ctrl: RTL
========================

// Module: junction_cycle_ctrl
// PURPOSE
// Sequences one layer junction's processor sets (FF, BP, UP) over the p*fo/z cycles needed per sample.
// Accepts samples on a valid/ready handshake and emits the per-cycle weight/bias memory read address.
// Emits a delayed write-back strobe, address and etapos aligned with the UP processor output.
// Sits between the network-level sample feeder and one junction's weight/bias memories and processor sets.
// PARAMETERS
// p         16  neurons in preceding layer
// fo        2   fan-out per preceding neuron
// z         8   weights processed per cycle (z/fi neurons per cycle)
// RD_LAT    1   weight/bias memory read latency, cycles
// PROC_LAT  1   FF/UP processor latency from memory data to updated weight, cycles
// ETA_W     4   etapos width (= $clog2(frac_bits+2))
// CNT_W     16  completed-sample counter width
// Derived: CPC = p*fo/z (cycles per sample), AW = $clog2(CPC), WB_LAT = RD_LAT+PROC_LAT
// PORTS
// clk          in   1      clock
// reset        in   1      synchronous, active-high reset
// in_valid     in   1      next sample's activations/deltas present
// in_ready     out  1      sample accepted when in_valid & in_ready
// etapos_cfg   in   ETA_W  learning-rate shift, sampled at acceptance
// rd_en        out  1      weight/bias memory read enable
// rd_addr      out  AW     read address = current cycle index
// cycle_idx    out  AW     cycle index within sample (selects act/del slice)
// wr_en        out  1      weight/bias memory write enable (update write-back)
// wr_addr      out  AW     write-back address
// etapos       out  ETA_W  to UP processor; 0 whenever wr_en=0
// sample_done  out  1      one-cycle pulse when a sample's last write-back occurs
// busy         out  1      state!=IDLE or write-back pipeline non-empty
// sample_cnt   out  CNT_W  completed samples, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters and write-back pipeline cleared.
// - Reset mid-sample: in-flight writes dropped; no wr_en after reset.
// - States IDLE, RUN, DRAIN.
// - IDLE: in_ready=1. On accept -> RUN; cycle_idx=0; latch etapos_cfg.
// - RUN: rd_en=1, rd_addr=cycle_idx, cycle_idx+1 per cycle.
// - RUN, last cycle (cycle_idx=CPC-1): in_ready=1; in_ready=0 on all other RUN cycles.
//   - Accept on last cycle: stay RUN, wrap cycle_idx to 0, no bubble, latch new etapos_cfg.
//   - No accept: -> DRAIN.
// - DRAIN: rd_en=0, in_ready=1; accept -> RUN (cycle_idx=0); pipeline empty and no accept -> IDLE.
// - in_valid while in_ready=0 is ignored; feeder holds it.
// - Write-back pipeline: WB_LAT-stage shift register of {rd_en, rd_addr, etapos_latched, last_flag}.
//   - Output stage drives wr_en, wr_addr, etapos, sample_done.
//   - wr_en at cycle t+WB_LAT for every rd_en at cycle t; exactly CPC writes per sample, in address order.
//   - etapos forced 0 when stage invalid.
// - sample_done = wr_en & last_flag; sample_cnt increments on the same cycle.
// - Hazard rule: same-address read-after-write distance is CPC, so WB_LAT < CPC is required.
//   - Elaboration $error if WB_LAT >= CPC or CPC < 2.
//   - Elaboration $error if p*fo is not a multiple of z.
// - Overlap: with back-to-back samples, writes of sample k overlap reads of sample k+1 at different addresses.
//   - Each write carries sample k's etapos even if etapos_cfg changed.
// - Read and write to the same address in one cycle cannot occur (guaranteed by hazard rule).
// - busy deasserts the cycle after the final wr_en when no new sample is accepted.
// STRUCTURE
// - Package dnn_ctrl_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DRAIN} jc_state_t
//   - function cpc(p,fo,z)
//   - localparam helper for AW
// - Sub-module wb_delay_line #(DEPTH, W): valid-tagged shift register, synchronous reset clears valid bits only.
// - FSM, cycle counter and sample counter live in junction_cycle_ctrl.
// TESTING (defaults: CPC=4, WB_LAT=2)
// - Reset then idle -> all outputs 0, in_ready=1, busy=0.
// - Single sample, etapos_cfg=3 -> rd_addr 0,1,2,3 on cycles 1-4.
//   - wr_en on cycles 3-6, wr_addr 0-3, etapos=3.
//   - sample_done on cycle 6; sample_cnt=1; busy low on cycle 7.
// - Three back-to-back samples, etapos_cfg 2,5,7 -> rd_en continuous for 12 cycles.
//   - Writes 0-3 repeat three times with etapos 2,5,7; sample_cnt=3.
// - in_valid held high in mid-RUN -> in_ready only on cycle_idx=3; no sample lost or duplicated.
// - Reset asserted at cycle_idx=2 -> next cycle wr_en=0, state IDLE, sample_cnt unchanged.
// - Set CNT_W=2; run 5 samples -> sample_cnt ends at 1.
// - Elaborate with p=8, fo=1, z=4 (CPC=2, WB_LAT=2) -> elaboration error.

Source files
------------

// File: rtl/dnn_ctrl_pkg.sv
// Shared types and elaboration helpers for the junction cycle controller.
package dnn_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} jc_state_t;

  // Cycles needed to stream one sample through a junction.
  function automatic int unsigned cpc(input int unsigned p, input int unsigned fo,
                                      input int unsigned z);
    return (p * fo) / z;
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefaultCpc = 4;
  localparam int unsigned DefaultAw  = addr_w(DefaultCpc);

endpackage

// File: rtl/junction_cycle_ctrl_if.sv
// Sample handshake plus memory-side control bundle of one junction controller.
interface junction_cycle_ctrl_if #(
  parameter int unsigned AW    = 2,
  parameter int unsigned ETA_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [ETA_W-1:0] etapos_cfg;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    cycle_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [ETA_W-1:0] etapos;
  logic             sample_done;
  logic             busy;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    input  in_valid, etapos_cfg,
    output in_ready, rd_en, rd_addr, cycle_idx, wr_en, wr_addr, etapos, sample_done, busy,
           sample_cnt
  );

  modport slave (
    output in_valid, etapos_cfg,
    input  in_ready, rd_en, rd_addr, cycle_idx, wr_en, wr_addr, etapos, sample_done, busy,
           sample_cnt
  );
endinterface

// File: rtl/wb_delay_line.sv
// Valid-tagged shift register; reset clears only the valid bits.
module wb_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pending
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  // Entries still upstream of the output stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      pending = pending | valid_q[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/junction_cycle_ctrl.sv
// Per-sample cycle sequencer for one layer junction: memory read stepping plus
// a delayed write-back stream aligned with the update processor output.
module junction_cycle_ctrl
  import dnn_ctrl_pkg::*;
#(
  parameter int unsigned p        = 16,
  parameter int unsigned fo       = 2,
  parameter int unsigned z        = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PROC_LAT = 1,
  parameter int unsigned ETA_W    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  junction_cycle_ctrl_if.master bus
);

  localparam int unsigned CPC    = cpc(p, fo, z);
  localparam int unsigned AW     = addr_w(CPC);
  localparam int unsigned WB_LAT = RD_LAT + PROC_LAT;
  localparam int unsigned WbW    = 1 + AW + ETA_W;
  localparam logic [AW-1:0] LastIdx = AW'(CPC - 1);

  // A weight row is rewritten before it is read again only if WB_LAT < CPC.
  if (WB_LAT >= CPC || CPC < 2) begin : g_bad_latency
    $error("junction_cycle_ctrl: need CPC >= 2 and WB_LAT < CPC (WB_LAT=%0d CPC=%0d)",
           WB_LAT, CPC);
  end
  if ((p * fo) % z != 0) begin : g_bad_ratio
    $error("junction_cycle_ctrl: p*fo (%0d) is not a multiple of z (%0d)", p * fo, z);
  end

  jc_state_t        state_q;
  logic [AW-1:0]    cyc_q;
  logic [ETA_W-1:0] eta_q;
  logic [CNT_W-1:0] cnt_q;

  logic             run;
  logic             run_last;
  logic [WbW-1:0]   wb_in;
  logic [WbW-1:0]   wb_out;
  logic             wb_valid;
  logic             wb_pending;
  logic             wb_last;
  logic [AW-1:0]    wb_addr;
  logic [ETA_W-1:0] wb_eta;

  assign run      = (state_q == RUN);
  assign run_last = run && (cyc_q == LastIdx);
  assign wb_in    = {run_last, cyc_q, eta_q};
  assign {wb_last, wb_addr, wb_eta} = wb_out;

  wb_delay_line #(
    .DEPTH(WB_LAT),
    .W    (WbW)
  ) u_wb (
    .clk      (clk),
    .reset    (reset),
    .in_valid (run),
    .in_data  (wb_in),
    .out_valid(wb_valid),
    .out_data (wb_out),
    .pending  (wb_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      eta_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (wb_valid && wb_last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= RUN;
            cyc_q   <= '0;
            eta_q   <= bus.etapos_cfg;
          end
        end
        RUN: begin
          if (cyc_q == LastIdx) begin
            cyc_q <= '0;
            if (bus.in_valid) begin
              eta_q <= bus.etapos_cfg;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            cyc_q <= cyc_q + AW'(1);
          end
        end
        DRAIN: begin
          if (bus.in_valid) begin
            state_q <= RUN;
            cyc_q   <= '0;
            eta_q   <= bus.etapos_cfg;
          end else if (!wb_pending) begin
            // Only the output stage may still hold a write; it retires this cycle.
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE) || (state_q == DRAIN) || run_last;
    bus.rd_en       = run;
    bus.rd_addr     = cyc_q;
    bus.cycle_idx   = cyc_q;
    bus.wr_en       = wb_valid;
    bus.wr_addr     = wb_valid ? wb_addr : '0;
    bus.etapos      = wb_valid ? wb_eta : '0;
    bus.sample_done = wb_valid && wb_last;
    bus.busy        = (state_q != IDLE) || wb_pending || wb_valid;
    bus.sample_cnt  = cnt_q;
  end

endmodule
